// File: rtl/button_event.sv
// button_event: turns a debounced, clk-synchronous button level into
// single-cycle press / release / auto-repeat events, a combined step pulse
// that advances the program counter, a held flag and a wrapping step count.
module button_event #(
    parameter int HOLD_CYCLES   = 25_000_000,  // press pulse to first repeat
    parameter int REPEAT_CYCLES = 5_000_000,   // spacing of later repeats
    parameter int CNT_W         = 32           // interval counter width
) (
    input  logic       clk,
    input  logic       rst,            // synchronous, active-high
    input  logic       level,          // debounced level, 1 = pressed
    output logic       press,          // one-cycle pulse on the press edge
    output logic       release_pulse,  // one-cycle pulse on the release edge
    output logic       repeat_pulse,   // one-cycle auto-repeat pulse
    output logic       step,           // press OR repeat: advances the PC
    output logic       held,           // high while the FSM is not idle
    output logic [7:0] step_count      // step pulses seen, wraps 255 -> 0
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_t;

    // Counter values at which the hold and repeat intervals expire.
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             lvl_q;
    logic             press_d, release_d, repeat_d, step_d, held_d;
    logic [7:0]       step_count_d;

    // Next-state and next-output decode; release beats an expiring interval.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d   = state;
        cnt_d     = cnt;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (level && !lvl_q) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!level) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt == HOLD_LAST) begin
                    state_d  = ST_REPEAT;
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!level) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        step_d       = press_d | repeat_d;
        held_d       = (state_d != ST_IDLE);
        step_count_d = step_d ? step_count + 8'd1 : step_count;
    end

    // State, counter, level history and registered outputs; reset wins.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values computed above.
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            lvl_q         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            step          <= 1'b0;
            held          <= 1'b0;
            step_count    <= 8'd0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            lvl_q         <= level;
            press         <= press_d;
            release_pulse <= release_d;
            repeat_pulse  <= repeat_d;
            step          <= step_d;
            held          <= held_d;
            step_count    <= step_count_d;
        end
    end

endmodule

// File: doc/button_event.md
# button_event

Converts the debounced button level into single-cycle, clock-synchronous step events for the program counter and shifter control logic. Sits directly downstream of the button debouncer. The block produces:
- a press pulse,
- a release pulse,
- a hold-to-auto-repeat pulse train,
- a held flag,
- a wrapping step counter.

## Interface
Parameters:
- HOLD_CYCLES, default 25_000_000: cycles from press pulse to first repeat pulse; legal range 2 .. 2^CNT_W-1.
- REPEAT_CYCLES, default 5_000_000: cycles between successive repeat pulses; legal range 1 .. 2^CNT_W-1.
- CNT_W, default 32: width of the internal interval counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- level  input  1  debounced button level, already synchronous to clk; 1 = pressed.
- press  output  1  one-cycle pulse on the press edge.
- release  output  1  one-cycle pulse on the release edge.
- repeat  output  1  one-cycle auto-repeat pulse while held.
- step  output  1  press OR repeat, registered; the pulse that advances the PC.
- held  output  1  high while the FSM is not IDLE.
- step_count  output  8  count of step pulses, wraps 255 -> 0.

## Operation
- Internal registers:
  - lvl_q: previous sampled level.
  - state: one of IDLE, HOLD, REPEAT.
  - cnt: CNT_W-bit interval counter.
- All outputs are registered. The pulse outputs are 0 on any cycle not named below.
- IDLE:
  - On an edge sampling level=1 with lvl_q=0: go to HOLD, cnt<=0, press<=1, step<=1.
- HOLD:
  - level=0: go to IDLE, cnt<=0, release<=1.
  - Otherwise cnt<=cnt+1.
  - When cnt==HOLD_CYCLES-1 with level=1: go to REPEAT, cnt<=0, repeat<=1, step<=1.
- REPEAT:
  - level=0: go to IDLE, cnt<=0, release<=1.
  - Otherwise cnt<=cnt+1.
  - When cnt==REPEAT_CYCLES-1 with level=1: cnt<=0, repeat<=1, step<=1.
- Release has priority over repeat. If level=0 is sampled on the edge where the counter would expire, only release fires.
- held<=1 on entry to HOLD; held<=0 on the same edge that returns the FSM to IDLE.
- step_count increments on every edge that sets step<=1. It is 8-bit unsigned and wraps modulo 256 with no saturation.
- Level already 1 when rst deasserts:
  - lvl_q resets to 0, so the first post-reset edge sampling level=1 produces a press.
  - This is intentional: a button held through reset yields one press.
- rst=1 mid-operation (any state, any cnt) takes priority over all other behaviour:
  - state<=IDLE, cnt<=0, lvl_q<=0.
  - press, release, repeat, step, held <= 0; step_count<=0.
  - No release pulse is generated for a reset that interrupts a hold.

## Timing
- Reset values: every output is 0.
- Press latency:
  - If edge k is the first edge sampling level=1, press, step and held are high in the cycle after edge k.
  - press and step are high for exactly 1 cycle; held stays high.
- First repeat: repeat and step are high after edge k+HOLD_CYCLES.
- Subsequent repeats: after edges k+HOLD_CYCLES+n*REPEAT_CYCLES, for n=1,2,...
- Release: if edge m is the first edge sampling level=0 after a press, release is high after edge m, and held is low from edge m.
- Minimum press: level high for exactly one sampled edge gives a press after edge k and a release after edge k+1, in consecutive cycles.
- Back-to-back: a new press can be accepted on the edge immediately after the release edge. The next edge sampling level=1 after IDLE is re-entered is treated as a fresh press.
- At most one of press/release/repeat is high in any cycle.

## Test plan
Bench parameters: HOLD_CYCLES=8, REPEAT_CYCLES=4.
- Reset with level=1, deassert rst at edge 0 -> all outputs 0 during rst; press=step=1 after edge 1, held=1; step_count=1.
- Level high from edge k for 20 edges -> press at k; repeat at k+8, k+12, k+16; release after k+20; step_count=4; held low after k+20.
- Level high for exactly one edge -> press after k, release after k+1; no repeat; step_count=1.
- Level drops on edge k+8, the hold-expiry edge -> release only; repeat never asserted; step_count=1.
- rst asserted at k+10 while in REPEAT -> after that edge all outputs 0 and step_count=0; no release pulse; with level still 1 after rst deasserts, a new press follows on the next edge.
- 256 short presses -> step_count wraps 255 -> 0 on the 256th press; press pulses remain exactly 1 cycle each.
